// File: rtl/apu_pkg.sv
// Shared definitions for the APU register front end and frame sequencer.
// Contents:
//   - register offsets from $4000 (square 1/2 bytes, status, frame counter)
//   - default frame-sequencer divider and step counts
//   - frame mode enum and the per-step action lookup
package apu_pkg;

  localparam logic [4:0] SQ1_0  = 5'h00;
  localparam logic [4:0] SQ1_1  = 5'h01;
  localparam logic [4:0] SQ1_2  = 5'h02;
  localparam logic [4:0] SQ1_3  = 5'h03;
  localparam logic [4:0] SQ2_0  = 5'h04;
  localparam logic [4:0] SQ2_1  = 5'h05;
  localparam logic [4:0] SQ2_2  = 5'h06;
  localparam logic [4:0] SQ2_3  = 5'h07;
  localparam logic [4:0] STATUS = 5'h15;
  localparam logic [4:0] FRAME  = 5'h17;

  // 1.789773 MHz CPU clock / 240 Hz quarter-frame rate
  localparam int FRAME_DIV_DEFAULT = 7457;
  localparam int STEPS_4 = 4;
  localparam int STEPS_5 = 5;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } frame_mode_e;

  typedef struct packed {
    logic q240;  // quarter-frame clock
    logic q120;  // half-frame clock
    logic irq;   // frame interrupt request
  } step_action_t;

  // What a divider wrap does while the sequencer sits at `step`.
  function automatic step_action_t step_action(frame_mode_e mode, logic [2:0] step);
    step_action_t a;
    a = '0;
    if (mode == MODE_4STEP) begin
      a.q240 = 1'b1;
      a.q120 = (step == 3'd1) || (step == 3'd3);
      a.irq  = (step == 3'd3);
    end else begin
      // Step 3 of the 5-step sequence is the silent one.
      a.q240 = (step != 3'd3);
      a.q120 = (step == 3'd1) || (step == 3'd4);
    end
    return a;
  endfunction

endpackage

// File: rtl/apu_frame_counter.sv
// Frame sequencer: divider, step counter, mode/inhibit, quarter/half-frame
// enables and the frame interrupt flag.
// Configuration macro: APU_FRAME_IRQ_EN (undefined -> frame_irq tied 0,
// irq_inhibit still stored but unused).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   frame_wr          one-cycle $4017 write strobe
//   frame_d7          written mode bit (1 = 5-step)
//   frame_d6          written irq_inhibit bit
//   status_rd         $4015 read strobe (clears frame_irq)
//   enable_240hz      registered quarter-frame pulse
//   enable_120hz      registered half-frame pulse
//   frame_irq         frame interrupt flag
module apu_frame_counter
  import apu_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_wr,
  input  logic frame_d7,
  input  logic frame_d6,
  input  logic status_rd,
  output logic enable_240hz,
  output logic enable_120hz,
  output logic frame_irq
);

  localparam int DIV_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(FRAME_DIV - 1);
  localparam logic [2:0] LAST_STEP_4 = 3'(STEPS_4 - 1);
  localparam logic [2:0] LAST_STEP_5 = 3'(STEPS_5 - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       step_q, step_d;
  frame_mode_e      mode_q, mode_d;
  logic             inhibit_q, inhibit_d;
  logic             q240_q, q240_d;
  logic             q120_q, q120_d;
  logic             irq_set;
  logic             wrap;
  step_action_t     act;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wrap      = (div_q == '0);
    act       = step_action(mode_q, step_q);
    div_d     = wrap ? DIV_RELOAD : div_q - 1'b1;
    step_d    = step_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    q240_d    = 1'b0;
    q120_d    = 1'b0;
    irq_set   = 1'b0;

    if (wrap) begin
      step_d  = (step_q == ((mode_q == MODE_5STEP) ? LAST_STEP_5 : LAST_STEP_4))
                ? 3'd0 : step_q + 3'd1;
      q240_d  = act.q240;
      q120_d  = act.q120;
      irq_set = act.irq;
    end

    // A $4017 write overrides a coincident wrap: the sequence restarts and
    // the wrap's step advance, pulses and IRQ request are all discarded.
    if (frame_wr) begin
      mode_d    = frame_mode_e'(frame_d7);
      inhibit_d = frame_d6;
      div_d     = DIV_RELOAD;
      step_d    = 3'd0;
      q240_d    = frame_d7;
      q120_d    = frame_d7;
      irq_set   = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= DIV_RELOAD;
      step_q    <= 3'd0;
      mode_q    <= MODE_4STEP;
      inhibit_q <= 1'b0;
      q240_q    <= 1'b0;
      q120_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      q240_q    <= q240_d;
      q120_q    <= q120_d;
    end
  end

  assign enable_240hz = q240_q;
  assign enable_120hz = q120_q;

`ifdef APU_FRAME_IRQ_EN
  logic irq_q;

  // Priority: inhibit-write clear, then set (beats a coincident status read),
  // then read clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (frame_wr && frame_d6) begin
      irq_q <= 1'b0;
    end else if (irq_set && !inhibit_q) begin
      irq_q <= 1'b1;
    end else if (status_rd) begin
      irq_q <= 1'b0;
    end
  end

  assign frame_irq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_set, inhibit_q, status_rd};
  assign frame_irq = 1'b0;
`endif

endmodule

// File: rtl/apu_register_frame.sv
// CPU-side APU front end: decodes writes to $4000-$4007, $4015, $4017,
// holds both square channels' register bytes with per-channel reload events,
// serves $4015 status reads, and hosts the frame sequencer.
// Configuration macro: APU_FRAME_IRQ_EN (frame IRQ logic; default off).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   bus_addr[4:0]           register offset from $4000
//   bus_wdata[7:0]          write data
//   bus_we, bus_re          one-cycle write / read strobes
//   bus_rdata[7:0]          read data, valid the cycle after bus_re
//   sq1_reg0..3, sq1_event  square 1 bytes, pulse when $4003 lands
//   sq2_reg0..3, sq2_event  square 2 bytes, pulse when $4007 lands
//   ch_enable[1:0]          $4015 bits {sq2, sq1}
//   enable_240hz/120hz      quarter/half-frame pulses
//   frame_irq               frame interrupt flag
module apu_register_frame
  import apu_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] bus_addr,
  input  logic [7:0] bus_wdata,
  input  logic       bus_we,
  input  logic       bus_re,
  output logic [7:0] bus_rdata,
  output logic [7:0] sq1_reg0,
  output logic [7:0] sq1_reg1,
  output logic [7:0] sq1_reg2,
  output logic [7:0] sq1_reg3,
  output logic       sq1_event,
  output logic [7:0] sq2_reg0,
  output logic [7:0] sq2_reg1,
  output logic [7:0] sq2_reg2,
  output logic [7:0] sq2_reg3,
  output logic       sq2_event,
  output logic [1:0] ch_enable,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq
);

  logic [7:0] sq1_q [4];
  logic [7:0] sq2_q [4];
  logic       sq1_wr, sq2_wr, status_wr, status_rd, frame_wr;

  // Each channel owns an aligned block of four offsets.
  assign sq1_wr    = bus_we && ((bus_addr & 5'h1C) == SQ1_0);
  assign sq2_wr    = bus_we && ((bus_addr & 5'h1C) == SQ2_0);
  assign status_wr = bus_we && (bus_addr == STATUS);
  assign frame_wr  = bus_we && (bus_addr == FRAME);
  assign status_rd = bus_re && (bus_addr == STATUS);

  // NOTE: the register-byte arrays are reset explicitly because the square
  // channels read them directly and must start from a known zero state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        sq1_q[i] <= 8'h00;
        sq2_q[i] <= 8'h00;
      end
      sq1_event <= 1'b0;
      sq2_event <= 1'b0;
      ch_enable <= 2'b00;
      bus_rdata <= 8'h00;
    end else begin
      if (sq1_wr) sq1_q[bus_addr[1:0]] <= bus_wdata;
      if (sq2_wr) sq2_q[bus_addr[1:0]] <= bus_wdata;
      if (status_wr) ch_enable <= bus_wdata[1:0];
      // Events rise together with the newly written length/timer-high byte.
      sq1_event <= bus_we && (bus_addr == SQ1_3);
      sq2_event <= bus_we && (bus_addr == SQ2_3);
      // Status is captured from pre-edge state, so a write in the same cycle
      // is not yet reflected.
      bus_rdata <= status_rd ? {1'b0, frame_irq, 4'b0000, ch_enable} : 8'h00;
    end
  end

  assign sq1_reg0 = sq1_q[0];
  assign sq1_reg1 = sq1_q[1];
  assign sq1_reg2 = sq1_q[2];
  assign sq1_reg3 = sq1_q[3];
  assign sq2_reg0 = sq2_q[0];
  assign sq2_reg1 = sq2_q[1];
  assign sq2_reg2 = sq2_q[2];
  assign sq2_reg3 = sq2_q[3];

  apu_frame_counter #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_counter (
    .clk          (clk),
    .reset        (reset),
    .frame_wr     (frame_wr),
    .frame_d7     (bus_wdata[7]),
    .frame_d6     (bus_wdata[6]),
    .status_rd    (status_rd),
    .enable_240hz (enable_240hz),
    .enable_120hz (enable_120hz),
    .frame_irq    (frame_irq)
  );

endmodule

// File: tb/tb_apu_register_frame.sv
// Directed bench for apu_register_frame with a short divider (FRAME_DIV=4).
// Expected values are queued when stimulus is applied and compared when the
// DUT output for that cycle is sampled, 1 time unit after the rising edge.
module tb_apu_register_frame;

  localparam int DIV = 4;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] bus_addr = 5'h00;
  logic [7:0] bus_wdata = 8'h00;
  logic       bus_we = 1'b0;
  logic       bus_re = 1'b0;
  logic [7:0] bus_rdata;
  logic [7:0] sq1_reg0, sq1_reg1, sq1_reg2, sq1_reg3;
  logic [7:0] sq2_reg0, sq2_reg1, sq2_reg2, sq2_reg3;
  logic       sq1_event, sq2_event;
  logic [1:0] ch_enable;
  logic       enable_240hz, enable_120hz, frame_irq;

  always #5 clk = ~clk;

  apu_register_frame #(.FRAME_DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_we       (bus_we),
    .bus_re       (bus_re),
    .bus_rdata    (bus_rdata),
    .sq1_reg0     (sq1_reg0),
    .sq1_reg1     (sq1_reg1),
    .sq1_reg2     (sq1_reg2),
    .sq1_reg3     (sq1_reg3),
    .sq1_event    (sq1_event),
    .sq2_reg0     (sq2_reg0),
    .sq2_reg1     (sq2_reg1),
    .sq2_reg2     (sq2_reg2),
    .sq2_reg3     (sq2_reg3),
    .sq2_event    (sq2_event),
    .ch_enable    (ch_enable),
    .enable_240hz (enable_240hz),
    .enable_120hz (enable_120hz),
    .frame_irq    (frame_irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=0x%0h expected=queued_entry", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_we = 1'b0;
    bus_re = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [7:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr);
    bus_addr = addr;
    bus_re   = 1'b1;
    tick();
    bus_re   = 1'b0;
  endtask

  function automatic logic [31:0] enables();
    return {29'd0, frame_irq, enable_120hz, enable_240hz};
  endfunction

  // Idle for n cycles; bit i of each mask is the expected value after tick i.
  task automatic watch(input string tag, input int n,
                       input bit [63:0] m240, input bit [63:0] m120, input bit [63:0] mirq);
    for (int i = 1; i <= n; i++) begin
      sb_push($sformatf("%s_c%0d", tag, i), {29'd0, mirq[i], m120[i], m240[i]});
      tick();
      sb_pop(enables());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    do_reset();
    check("rst_sq1_reg3", sq1_reg3, 8'h00);
    check("rst_sq2_reg0", sq2_reg0, 8'h00);
    check("rst_events", {sq1_event, sq2_event}, 2'b00);
    check("rst_ch_enable", ch_enable, 2'b00);
    check("rst_enables", enables(), 32'd0);
    check("rst_rdata", bus_rdata, 8'h00);

    // ---- 4-step sequence from reset: pulses at ticks 4/8/12/16 ----
    watch("four_step", 16, 64'h11110, 64'h10100, IRQ_EN ? 64'h10000 : 64'h0);

    // ---- status read clears IRQ; simultaneous $4015 write and read ----
    bus_addr  = 5'h15;
    bus_wdata = 8'h03;
    bus_we    = 1'b1;
    bus_re    = 1'b1;
    sb_push("rd1_rdata", IRQ_EN ? 32'h40 : 32'h00);
    sb_push("rd1_ch_enable", 32'h3);
    sb_push("rd1_irq_cleared", 32'h0);
    tick();
    bus_we = 1'b0;
    bus_re = 1'b0;
    sb_pop(bus_rdata);
    sb_pop(ch_enable);
    sb_pop(frame_irq);
    sb_push("rd2_rdata", 32'h03);
    bus_read(5'h15);
    sb_pop(bus_rdata);
    sb_push("rd_other_addr", 32'h00);
    bus_read(5'h03);
    sb_pop(bus_rdata);

    // ---- register writes and events ----
    do_reset();
    sb_push("w4003_reg", 32'hF8);
    sb_push("w4003_ev1", 32'h1);
    sb_push("w4003_ev2", 32'h0);
    bus_write(5'h03, 8'hF8);
    sb_pop(sq1_reg3);
    sb_pop(sq1_event);
    sb_pop(sq2_event);
    sb_push("w4003_ev1_done", 32'h0);
    tick();
    sb_pop(sq1_event);
    sb_push("w4007_reg", 32'h5A);
    sb_push("w4007_evs", 32'h2);
    bus_write(5'h07, 8'h5A);
    sb_pop(sq2_reg3);
    sb_pop({30'd0, sq2_event, sq1_event});
    sb_push("w4002_reg", 32'h11);
    sb_push("w4002_evs", 32'h0);
    bus_write(5'h02, 8'h11);
    sb_pop(sq1_reg2);
    sb_pop({30'd0, sq2_event, sq1_event});
    bus_write(5'h04, 8'h22);
    bus_write(5'h08, 8'hFF);
    bus_write(5'h1F, 8'hEE);
    bus_write(5'h16, 8'hFF);
    check("unmapped_sq1", {sq1_reg0, sq1_reg1, sq1_reg2, sq1_reg3}, 32'h000011F8);
    check("unmapped_sq2", {sq2_reg0, sq2_reg1, sq2_reg2, sq2_reg3}, 32'h2200005A);
    check("unmapped_ch_enable", ch_enable, 2'b00);

    // ---- 5-step mode via $4017=80 ----
    do_reset();
    sb_push("w4017_80_pulse", 32'h3);
    bus_write(5'h17, 8'h80);
    sb_pop(enables());
    watch("five_step", 24, 64'h1101110, 64'h100100, 64'h0);

    // ---- $4017 write in the divider-wrap cycle ----
    do_reset();
    watch("pre_wrap", 3, 64'h0, 64'h0, 64'h0);
    sb_push("wrap_write_nopulse", 32'h0);
    bus_write(5'h17, 8'h00);
    sb_pop(enables());
    watch("post_wrap_write", 4, 64'h10, 64'h0, 64'h0);

    // ---- $4017 write in the step-3 wrap suppresses the IRQ ----
    do_reset();
    watch("pre_step3", 15, 64'h1110, 64'h100, 64'h0);
    sb_push("step3_write_noirq", 32'h0);
    bus_write(5'h17, 8'h00);
    sb_pop(enables());

    // ---- status read in the cycle the IRQ is set: set wins ----
    do_reset();
    watch("pre_set", 15, 64'h1110, 64'h100, 64'h0);
    sb_push("set_vs_read_rdata", 32'h00);
    sb_push("set_vs_read_flags", IRQ_EN ? 32'h7 : 32'h3);
    bus_read(5'h15);
    sb_pop(bus_rdata);
    sb_pop(enables());

    // ---- irq_inhibit keeps the flag clear ----
    do_reset();
    sb_push("inhibit_write", 32'h0);
    bus_write(5'h17, 8'h40);
    sb_pop(enables());
    watch("inhibit_run", 16, 64'h11110, 64'h10100, 64'h0);

    // ---- reset in the middle of step 2 ----
    do_reset();
    bus_write(5'h00, 8'hAA);
    bus_write(5'h15, 8'h02);
    watch("pre_midreset", 8, 64'h44, 64'h40, 64'h0);
    check("pre_midreset_reg", sq1_reg0, 8'hAA);
    reset = 1'b1;
    tick();
    check("midreset_sq1_reg0", sq1_reg0, 8'h00);
    check("midreset_ch_enable", ch_enable, 2'b00);
    check("midreset_enables", enables(), 32'd0);
    reset = 1'b0;
    watch("restart", 4, 64'h10, 64'h0, 64'h0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
